spi_register_writer: RTL and testbench

SPI_REGISTER_WRITER -- requirements
Module: spi_register_writer

---
 rtl/synth_pkg.sv | 19 +
 rtl/spi_input_sync.sv | 25 ++
 rtl/spi_register_writer.sv | 137 +++++++++++++
 tb/tb_spi_register_writer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared widths and types for the SPI register writer.
// The frame is the register number followed by the value, MSB first.
package synth_pkg;

  localparam int SPI_FRAME_BITS   = 24;
  localparam int REG_NUMBER_WIDTH = 16;
  localparam int REG_VALUE_WIDTH  = 8;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int BIT_CNT_WIDTH    = 5;

  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT_INDEX = BIT_CNT_WIDTH'(SPI_FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_ACTIVE
  } spi_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
// RESET_VALUE is the idle level of the pin, so reset does not fake an edge.
module spi_input_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic data_async,
  output logic data_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], data_async};
    end
  end

  assign data_sync = sync_q[STAGES-1];

endmodule

// File: rtl/spi_register_writer.sv
// SPI mode-0 slave: 24-bit frames become register writes, and the latest
// synth sample is shifted back on MISO during each frame.
//
// state    | meaning
// S_FLUSH  | after reset; wait for synchronizers to flush and CS_N to be seen high
// S_IDLE   | CS_N high; a low CS_N here is a genuine falling edge
// S_ACTIVE | CS_N low; SCK edges are qualified
module spi_register_writer
  import synth_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_SPI_SCK,
  input  logic                        i_SPI_CS_N,
  input  logic                        i_SPI_MOSI,
  output logic                        o_SPI_MISO,
  output logic                        o_RegisterWriteEnable,
  output logic [REG_NUMBER_WIDTH-1:0] o_RegisterNumber,
  output logic [REG_VALUE_WIDTH-1:0]  o_RegisterValue,
  input  logic signed [SAMPLE_WIDTH-1:0] i_Sample,
  input  logic                        i_SampleReady
);

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic sck_sync, cs_n_sync, mosi_sync, sck_prev;
  logic sck_rise, sck_fall, rise_q, fall_q;
  logic frame_start, in_frame, frame_done;

  spi_state_t state, state_next;
  logic [FLUSH_W-1:0]        flush_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic [SPI_FRAME_BITS-2:0] shift_in;
  logic [SPI_FRAME_BITS-1:0] frame_word;
  logic [SAMPLE_WIDTH-1:0]   latest_sample, miso_sr, load_value;
  logic                      hold_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .data_async(i_SPI_SCK), .data_sync(sck_sync)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs_n (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .data_async(i_SPI_CS_N), .data_sync(cs_n_sync)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .data_async(i_SPI_MOSI), .data_sync(mosi_sync)
  );

  assign sck_rise   = sck_sync & ~sck_prev;
  assign sck_fall   = ~sck_sync & sck_prev;
  assign rise_q     = in_frame & sck_rise;
  assign fall_q     = in_frame & sck_fall;
  assign frame_done = rise_q && (bit_cnt == LAST_BIT_INDEX);
  assign frame_word = {shift_in, mosi_sync};
  assign load_value = i_SampleReady ? i_Sample : latest_sample;
  assign o_SPI_MISO = in_frame & miso_sr[SAMPLE_WIDTH-1];

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= S_FLUSH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    in_frame    = 1'b0;
    case (state)
      S_FLUSH: begin
        if ((flush_cnt == '0) && cs_n_sync) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (!cs_n_sync) begin
          state_next  = S_ACTIVE;
          frame_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cs_n_sync) state_next = S_IDLE;
        else           in_frame   = 1'b1;
      end
      default: state_next = S_FLUSH;
    endcase
  end

  // Reset presets the synchronizers; their contents are only trusted once flushed.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      flush_cnt <= FLUSH_W'(SYNC_STAGES);
      sck_prev  <= 1'b0;
    end else begin
      sck_prev <= sck_sync;
      if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bit_cnt               <= '0;
      shift_in              <= '0;
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterNumber      <= '0;
      o_RegisterValue       <= '0;
      latest_sample         <= '0;
      miso_sr               <= '0;
      hold_fall             <= 1'b0;
    end else begin
      o_RegisterWriteEnable <= frame_done;
      if (i_SampleReady) latest_sample <= i_Sample;

      if (!in_frame) begin
        bit_cnt <= '0;
      end else if (rise_q) begin
        shift_in <= frame_word[SPI_FRAME_BITS-2:0];
        bit_cnt  <= frame_done ? '0 : bit_cnt + 1'b1;
      end

      if (frame_done) begin
        o_RegisterNumber <= frame_word[SPI_FRAME_BITS-1:REG_VALUE_WIDTH];
        o_RegisterValue  <= frame_word[REG_VALUE_WIDTH-1:0];
      end

      // A boundary reload happens on a rise, so the fall that follows it must not shift.
      if (frame_start || frame_done) begin
        miso_sr   <= load_value;
        hold_fall <= frame_done;
      end else if (fall_q) begin
        if (hold_fall) hold_fall <= 1'b0;
        else           miso_sr   <= {miso_sr[SAMPLE_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_register_writer.sv
// Self-checking bench: directed frame table, reset-abort sequence and
// randomized frames against a frame-level reference model.
module tb_spi_register_writer;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_SPI_SCK = 1'b0;
  logic        i_SPI_CS_N = 1'b1;
  logic        i_SPI_MOSI = 1'b0;
  logic        o_SPI_MISO;
  logic        o_RegisterWriteEnable;
  logic [15:0] o_RegisterNumber;
  logic [7:0]  o_RegisterValue;
  logic signed [15:0] i_Sample = '0;
  logic        i_SampleReady = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_register_writer #(.SYNC_STAGES(2)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_SPI_SCK(i_SPI_SCK), .i_SPI_CS_N(i_SPI_CS_N), .i_SPI_MOSI(i_SPI_MOSI),
    .o_SPI_MISO(o_SPI_MISO),
    .o_RegisterWriteEnable(o_RegisterWriteEnable),
    .o_RegisterNumber(o_RegisterNumber), .o_RegisterValue(o_RegisterValue),
    .i_Sample(i_Sample), .i_SampleReady(i_SampleReady)
  );

  always #5 i_Clock = ~i_Clock;

  // Observed writes and over-long strobes.
  logic [23:0] wr_q[$];
  logic        we_prev = 1'b0;
  int          we_long = 0;
  always @(negedge i_Clock) begin
    if (o_RegisterWriteEnable) begin
      wr_q.push_back({o_RegisterNumber, o_RegisterValue});
      if (we_prev) we_long++;
    end
    we_prev = o_RegisterWriteEnable;
  end

  // Reference model state: latest sample, value loaded for the current frame, CS level.
  logic [15:0] latest_m = '0;
  logic [15:0] loaded_m = '0;
  bit          cs_low_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put_sample(input logic [15:0] v);
    @(negedge i_Clock);
    i_Sample = v;
    i_SampleReady = 1'b1;
    @(negedge i_Clock);
    i_SampleReady = 1'b0;
    latest_m = v;
  endtask

  // Sends nbits of frame MSB first; host reads MISO just before each rising SCK.
  task automatic run_frame(input logic [23:0] frame, input int nbits, input bit raise,
                           input bit pre_v, input logic [15:0] pre,
                           input bit mid_v, input logic [15:0] mid,
                           output logic [23:0] miso_word, output logic [15:0] exp_miso,
                           output int nwr, output logic [23:0] wr);
    int start;
    start = wr_q.size();
    miso_word = '0;
    wr = '0;
    if (pre_v) put_sample(pre);
    if (!cs_low_m) begin
      i_SPI_CS_N = 1'b0;
      repeat (8) @(negedge i_Clock);
      loaded_m = latest_m;
      cs_low_m = 1;
    end
    exp_miso = loaded_m;
    for (int i = 0; i < nbits; i++) begin
      if (mid_v && i == 8) put_sample(mid);
      i_SPI_MOSI = frame[23-i];
      repeat (4) @(negedge i_Clock);
      miso_word[23-i] = o_SPI_MISO;
      i_SPI_SCK = 1'b1;
      repeat (4) @(negedge i_Clock);
      i_SPI_SCK = 1'b0;
    end
    i_SPI_MOSI = 1'b0;
    if (nbits == 24) loaded_m = latest_m;
    repeat (4) @(negedge i_Clock);
    if (raise) begin
      i_SPI_CS_N = 1'b1;
      cs_low_m = 0;
      repeat (8) @(negedge i_Clock);
      check("miso_idle", {31'd0, o_SPI_MISO}, 32'd0);
    end
    nwr = wr_q.size() - start;
    if (nwr > 0) wr = wr_q[start];
  endtask

  typedef struct {
    logic [23:0] frame;
    int          nbits;
    bit          raise;
    bit          pre_v;
    logic [15:0] pre;
    bit          mid_v;
    logic [15:0] mid;
    bit          exp_wr;
    logic [23:0] exp_write;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [23:0] miso_word, wr, frame;
    logic [15:0] exp_miso, smp_a, smp_b;
    int nwr, nbits;
    bit raise, pre_v, mid_v;

    vecs[0] = '{24'hC0057F, 24, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 24'hC0057F, 16'h0000};
    vecs[1] = '{24'h800101, 24, 1'b0, 1'b1, 16'h1234, 1'b1, 16'hFEDC, 1'b1, 24'h800101, 16'h1234};
    vecs[2] = '{24'hC10A34, 24, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 24'hC10A34, 16'hFEDC};
    vecs[3] = '{24'hABCDEF, 10, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 24'h000000, 16'h0000};
    vecs[4] = '{24'h820012, 24, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 24'h820012, 16'hFEDC};

    repeat (5) @(negedge i_Clock);
    i_Reset = 1'b0;
    repeat (6) @(negedge i_Clock);
    check("rst_we",   {31'd0, o_RegisterWriteEnable}, 32'd0);
    check("rst_num",  {16'd0, o_RegisterNumber}, 32'd0);
    check("rst_val",  {24'd0, o_RegisterValue}, 32'd0);
    check("rst_miso", {31'd0, o_SPI_MISO}, 32'd0);

    foreach (vecs[k]) begin
      run_frame(vecs[k].frame, vecs[k].nbits, vecs[k].raise, vecs[k].pre_v, vecs[k].pre,
                vecs[k].mid_v, vecs[k].mid, miso_word, exp_miso, nwr, wr);
      check($sformatf("vec%0d_nwr", k), nwr, {31'd0, vecs[k].exp_wr});
      if (vecs[k].exp_wr) begin
        check($sformatf("vec%0d_write", k), {8'd0, wr}, {8'd0, vecs[k].exp_write});
        check($sformatf("vec%0d_miso", k), {8'd0, miso_word}, {8'd0, vecs[k].exp_miso, 8'h00});
      end
    end

    // Reset in mid-frame with CS_N held low: remaining bits must be ignored.
    run_frame(24'hFFFFFF, 12, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, miso_word, exp_miso, nwr, wr);
    check("pre_rst_nwr", nwr, 0);
    @(negedge i_Clock);
    i_Reset = 1'b1;
    repeat (2) @(negedge i_Clock);
    i_Reset = 1'b0;
    latest_m = '0;
    loaded_m = '0;
    @(negedge i_Clock);
    check("mid_rst_we",   {31'd0, o_RegisterWriteEnable}, 32'd0);
    check("mid_rst_num",  {16'd0, o_RegisterNumber}, 32'd0);
    check("mid_rst_val",  {24'd0, o_RegisterValue}, 32'd0);
    check("mid_rst_miso", {31'd0, o_SPI_MISO}, 32'd0);
    run_frame(24'hFFFFFF, 12, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, miso_word, exp_miso, nwr, wr);
    check("post_rst_ignored", nwr, 0);
    run_frame(24'hC20155, 24, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, miso_word, exp_miso, nwr, wr);
    check("post_rst_nwr", nwr, 1);
    check("post_rst_write", {8'd0, wr}, 32'h00C20155);
    check("post_rst_miso", {8'd0, miso_word}, 32'd0);

    // Randomized frames, bursts, partial frames and sample updates.
    for (int n = 0; n < 30; n++) begin
      frame = 24'($urandom);
      nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 23)) : 24;
      raise = (nbits != 24) || ($urandom_range(0, 2) == 0);
      pre_v = $urandom_range(0, 1) == 1;
      mid_v = $urandom_range(0, 1) == 1;
      smp_a = 16'($urandom);
      smp_b = 16'($urandom);
      run_frame(frame, nbits, raise, pre_v, smp_a, mid_v, smp_b, miso_word, exp_miso, nwr, wr);
      if (nbits == 24) begin
        check($sformatf("rnd%0d_nwr", n), nwr, 1);
        check($sformatf("rnd%0d_write", n), {8'd0, wr}, {8'd0, frame});
        check($sformatf("rnd%0d_miso", n), {8'd0, miso_word}, {8'd0, exp_miso, 8'h00});
      end else begin
        check($sformatf("rnd%0d_partial_nwr", n), nwr, 0);
      end
    end

    check("we_single_cycle", we_long, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
